// File: rtl/unsigned_divider.sv
// unsigned_divider
//   Restoring 8-bit / 4-bit unsigned divider producing one quotient bit per
//   clock, MSB first. A zero divisor skips the iteration and returns a
//   saturated quotient together with a divide-by-zero flag.
//
// Ports
//   clk_in        : rising-edge clock
//   rst_n_in      : asynchronous active-low reset
//   start_in      : begin a division (sampled only while idle)
//   A_in          : 8-bit unsigned dividend
//   B_in          : 4-bit unsigned divisor
//   quotient_out  : 8-bit quotient, held until the next result
//   remainder_out : 4-bit remainder, held until the next result
//   busy_out      : high while a division is in progress
//   done_out      : one-cycle pulse when the result outputs are updated
//   div_zero_out  : set when the last completed division had a zero divisor
module unsigned_divider (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       start_in,
  input  logic [7:0] A_in,
  input  logic [3:0] B_in,
  output logic [7:0] quotient_out,
  output logic [3:0] remainder_out,
  output logic       busy_out,
  output logic       done_out,
  output logic       div_zero_out
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t     state, state_next;

  // dvd_q holds the dividend; quotient bits shift in from the LSB as the
  // dividend bits shift out of the MSB, so it ends up holding the quotient.
  logic [7:0] dvd_q;
  logic [3:0] dvs_q;
  logic [4:0] rem_q;
  logic [2:0] cnt_q;
  logic       dz_q;

  logic [5:0] shifted;
  logic [4:0] diff;
  logic       fits;

  always_comb begin
    shifted = {rem_q, dvd_q[7]};
    fits    = (shifted >= {2'b00, dvs_q});
    diff    = shifted[4:0] - {1'b0, dvs_q};
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start_in) state_next = (B_in == 4'd0) ? DONE : CALC;
      CALC: if (cnt_q == 3'd7) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      dvd_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      dz_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_in) begin
            dvd_q <= A_in;
            dvs_q <= B_in;
            rem_q <= '0;
            cnt_q <= '0;
            dz_q  <= (B_in == 4'd0);
          end
        end
        CALC: begin
          rem_q <= fits ? diff : shifted[4:0];
          dvd_q <= {dvd_q[6:0], fits};
          cnt_q <= cnt_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Result, done and busy are registered: the result becomes visible one
  // edge after the FSM enters DONE, which sets the overall latency
  // (9 edges after start, 1 edge for a zero divisor).
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      quotient_out  <= '0;
      remainder_out <= '0;
      div_zero_out  <= 1'b0;
      done_out      <= 1'b0;
      busy_out      <= 1'b0;
    end else begin
      done_out <= (state == DONE);
      busy_out <= (state_next != IDLE) || (state == DONE);
      if (state == DONE) begin
        quotient_out  <= dz_q ? '1 : dvd_q;
        remainder_out <= dz_q ? dvd_q[3:0] : rem_q[3:0];
        div_zero_out  <= dz_q;
      end
    end
  end

endmodule

// File: tb/tb_unsigned_divider.sv
module tb_unsigned_divider;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a_in;
  logic [3:0] b_in;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_zero;

  unsigned_divider dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .start_in      (start),
    .A_in          (a_in),
    .B_in          (b_in),
    .quotient_out  (quotient),
    .remainder_out (remainder),
    .busy_out      (busy),
    .done_out      (done),
    .div_zero_out  (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [3:0]  b;
    logic [7:0]  q;
    logic [3:0]  r;
    logic        dz;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          done_seen = 0;
  int          n_pushed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected result per observed done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && done === 1'b1) begin
      done_seen++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_zero", div_zero, e.dz);
        chk("done_cycle", cyc, e.cyc);
        if (e.b != 4'd0) begin
          chk("identity", int'(quotient) * int'(e.b) + int'(remainder), int'(e.a));
          chk("rem_lt_div", remainder < e.b, 1);
        end
      end
    end
  end

  task automatic push_exp(input logic [7:0] a, input logic [3:0] b, input logic [7:0] q,
                          input logic [3:0] r, input logic dz, input int unsigned lat);
    exp_t e;
    e.a = a; e.b = b; e.q = q; e.r = r; e.dz = dz;
    e.cyc = cyc + 1 + lat;
    sb.push_back(e);
    n_pushed++;
  endtask

  task automatic issue(input logic [7:0] a, input logic [3:0] b, input logic [7:0] q,
                       input logic [3:0] r, input logic dz, input bit push);
    @(negedge clk);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    if (push) push_exp(a, b, q, r, dz, (b == 4'd0) ? 1 : 9);
    @(negedge clk);
    start = 1'b0;
    a_in  = 8'($urandom);
    b_in  = 4'($urandom);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (sb.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(negedge clk);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_div_zero", div_zero, 0);
    rst_n = 1'b1;

    issue(8'd9, 4'd3, 8'd3, 4'd0, 1'b0, 1'b1);
    chk("busy_calc", busy, 1);
    wait_idle();
    chk("busy_idle", busy, 0);
    issue(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 1'b1);   wait_idle();
    issue(8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 1'b1);  wait_idle();
    issue(8'h5A, 4'd0, 8'hFF, 4'hA, 1'b1, 1'b1);    wait_idle();
    issue(8'd6, 4'd2, 8'd3, 4'd0, 1'b0, 1'b1);      wait_idle();
    issue(8'h37, 4'd0, 8'hFF, 4'h7, 1'b1, 1'b1);    wait_idle();
    issue(8'd0, 4'd15, 8'd0, 4'd0, 1'b0, 1'b1);     wait_idle();
    issue(8'd14, 4'd15, 8'd0, 4'd14, 1'b0, 1'b1);   wait_idle();

    // Results hold after done.
    repeat (5) @(negedge clk);
    chk("hold_quotient", quotient, 0);
    chk("hold_remainder", remainder, 14);

    // Start pulse during CALC is ignored.
    issue(8'd42, 4'd6, 8'd7, 4'd0, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b1; a_in = 8'd1; b_in = 4'd1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (15) @(negedge clk);

    // Back-to-back: start held high across DONE is sampled again.
    @(negedge clk);
    start = 1'b1; a_in = 8'd20; b_in = 4'd3;
    push_exp(8'd20, 4'd3, 8'd6, 4'd2, 1'b0, 9);
    push_exp(8'd20, 4'd3, 8'd6, 4'd2, 1'b0, 19);
    repeat (11) @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Reset in the 4th CALC cycle aborts the operation.
    issue(8'd100, 4'd3, 8'd0, 4'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_div_zero", div_zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = done_seen;
    repeat (15) @(negedge clk);
    chk("no_done_after_abort", done_seen, n);
    issue(8'd15, 4'd4, 8'd3, 4'd3, 1'b0, 1'b1);
    wait_idle();

    // Exhaustive nonzero-divisor sweep.
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        issue(8'(a), 4'(b), 8'(a / b), 4'(a % b), 1'b0, 1'b1);
        wait_idle();
      end
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    chk("done_count", done_seen, n_pushed);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
